// File: rtl/slow_pkg.sv
// -----------------------------------------------------------------------------
// slow_pkg
//  Shared definitions for the slow-mode scheduler.
//  - slowState_t : scheduler state encoding (FAST/TOSLOW/SLOW/TOFAST)
//  - IACK..SND   : bit positions of the six peripheral select/enable pairs
//  - TO_SCALE_DEF: default number of extra low-order hold-counter bits
// -----------------------------------------------------------------------------
package slow_pkg;

  typedef enum logic [1:0] {
    FAST   = 2'b00,
    TOSLOW = 2'b01,
    SLOW   = 2'b10,
    TOFAST = 2'b11
  } slowState_t;

  localparam int IACK    = 0;
  localparam int VIA     = 1;
  localparam int IWM     = 2;
  localparam int SCC     = 3;
  localparam int SCSI    = 4;
  localparam int SND     = 5;
  localparam int NUM_DEV = 6;

  localparam int TO_SCALE_DEF = 4;

endpackage

// File: rtl/slow_hold_ctr.sv
// -----------------------------------------------------------------------------
// slow_hold_ctr
//  Hold-time down-counter for slow mode. Load has priority over decrement;
//  decrement saturates at zero so the counter never wraps.
//  Ports:
//    CLK     in  clock
//    nPOR    in  asynchronous active-low reset (clears count)
//    load    in  load loadVal this cycle
//    dec     in  decrement by one (ignored when load or count==0)
//    loadVal in  W-bit reload value
//    isZero  out count equals zero
// -----------------------------------------------------------------------------
module slow_hold_ctr #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         nPOR,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] loadVal,
  output logic         isZero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign isZero = (count == '0);

endmodule

// File: rtl/slow_sched.sv
// -----------------------------------------------------------------------------
// slow_sched
//  Slow-mode scheduler for the accelerator bus. When the CPU touches a
//  peripheral whose slow bit is set, it asks the clock switcher for the slow
//  clock and stalls the access until the switch is acknowledged. Slow mode is
//  held for SlowTimeout * 2^TO_SCALE Tick pulses after the last slow access.
//  Ports:
//    CLK, nPOR            clock, asynchronous active-low reset
//    BACT                 CPU bus cycle active
//    Tick                 hold countdown timebase strobe
//    *CS                  decoded peripheral selects
//    Slow*                per-device slow enables
//    SlowClockGate        gate fast clock while slow
//    SlowTimeout[3:0]     hold-time setting
//    SlowAck              clock switcher reports slow clock in effect
//    SlowReq              request slow clock (registered)
//    BusHold              stall current CPU access (combinational)
//    ClockGate            fast-clock gate enable (registered)
//    SlowActive           scheduler is in SLOW (registered)
// -----------------------------------------------------------------------------
module slow_sched
  import slow_pkg::*;
#(
  parameter int TO_SCALE = TO_SCALE_DEF
) (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       Tick,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  input  logic       SlowAck,
  output logic       SlowReq,
  output logic       BusHold,
  output logic       ClockGate,
  output logic       SlowActive
);

  localparam int CW = 4 + TO_SCALE;

  logic [NUM_DEV-1:0] csVec;
  logic [NUM_DEV-1:0] enVec;
  logic [NUM_DEV-1:0] hitVec;
  logic               hit;

  assign csVec[IACK] = IACKCS;
  assign csVec[VIA]  = VIACS;
  assign csVec[IWM]  = IWMCS;
  assign csVec[SCC]  = SCCCS;
  assign csVec[SCSI] = SCSICS;
  assign csVec[SND]  = SndCS;

  assign enVec[IACK] = SlowIACK;
  assign enVec[VIA]  = SlowVIA;
  assign enVec[IWM]  = SlowIWM;
  assign enVec[SCC]  = SlowSCC;
  assign enVec[SCSI] = SlowSCSI;
  assign enVec[SND]  = SlowSnd;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEV; gi++) begin : gHit
      assign hitVec[gi] = csVec[gi] & enVec[gi];
    end
  endgenerate

  assign hit = BACT & (|hitVec);

  slowState_t state, stateNext;
  logic       hitSeen, hitSeenNext;
  logic       ctrLoad, ctrDec, ctrZero;

  slow_hold_ctr #(.W(CW)) uHoldCtr (
    .CLK     (CLK),
    .nPOR    (nPOR),
    .load    (ctrLoad),
    .dec     (ctrDec),
    .loadVal ({SlowTimeout, {TO_SCALE{1'b0}}}),
    .isZero  (ctrZero)
  );

  always_comb begin
    stateNext   = state;
    hitSeenNext = 1'b0;
    ctrLoad     = 1'b0;
    ctrDec      = 1'b0;
    case (state)
      FAST: begin
        if (hit) stateNext = TOSLOW;
      end
      TOSLOW: begin
        // Counter is primed on entry so the stalled access gets a full hold.
        if (SlowAck) begin
          stateNext = SLOW;
          ctrLoad   = 1'b1;
        end
      end
      SLOW: begin
        ctrLoad = hit;
        ctrDec  = Tick;
        // Losing the ack while slow means the switcher is out of step:
        // go back and re-request rather than run a slow device fast.
        if (!SlowAck) begin
          stateNext = TOSLOW;
        end else if (ctrZero && !BACT) begin
          stateNext = TOFAST;
        end
      end
      TOFAST: begin
        // A slow access arriving mid-release must still wait for the
        // switcher to finish going fast before re-requesting.
        hitSeenNext = hitSeen | hit;
        if (!SlowAck) begin
          hitSeenNext = 1'b0;
          stateNext   = (hitSeen | hit) ? TOSLOW : FAST;
        end
      end
      default: stateNext = FAST;
    endcase
  end

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state      <= FAST;
      hitSeen    <= 1'b0;
      SlowReq    <= 1'b0;
      ClockGate  <= 1'b0;
      SlowActive <= 1'b0;
    end else begin
      state      <= stateNext;
      hitSeen    <= hitSeenNext;
      SlowReq    <= (stateNext == TOSLOW) || (stateNext == SLOW);
      ClockGate  <= SlowClockGate && (stateNext == SLOW);
      SlowActive <= (stateNext == SLOW);
    end
  end

  assign BusHold = hit & (state != SLOW);

endmodule

// File: tb/tb_slow_sched.sv
module tb_slow_sched;
  import slow_pkg::*;

  localparam int NONE = -1;

  logic       CLK = 1'b0;
  logic       nPOR;
  logic       BACT, Tick;
  logic       IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS;
  logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
  logic       SlowClockGate;
  logic [3:0] SlowTimeout;
  logic       SlowAck;
  logic       SlowReq, BusHold, ClockGate, SlowActive;

  int compared   = 0;
  int mismatched = 0;

  // Expected {SlowReq, BusHold, ClockGate, SlowActive} per driven cycle.
  logic [3:0] sbQ[$];
  string      tagQ[$];

  always #5 CLK = ~CLK;

  slow_sched dut (
    .CLK(CLK), .nPOR(nPOR), .BACT(BACT), .Tick(Tick),
    .IACKCS(IACKCS), .VIACS(VIACS), .IWMCS(IWMCS),
    .SCCCS(SCCCS), .SCSICS(SCSICS), .SndCS(SndCS),
    .SlowIACK(SlowIACK), .SlowVIA(SlowVIA), .SlowIWM(SlowIWM),
    .SlowSCC(SlowSCC), .SlowSCSI(SlowSCSI), .SlowSnd(SlowSnd),
    .SlowClockGate(SlowClockGate), .SlowTimeout(SlowTimeout),
    .SlowAck(SlowAck), .SlowReq(SlowReq), .BusHold(BusHold),
    .ClockGate(ClockGate), .SlowActive(SlowActive)
  );

  task automatic chkEq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b (Req,Hold,Gate,Act)", tag, obs, exp);
    end else begin
      $display("ok   %s: %b", tag, obs);
    end
  endtask

  task automatic setCs(input int dev);
    logic [5:0] cs;
    cs = 6'b0;
    if (dev >= 0) cs[dev] = 1'b1;
    IACKCS = cs[IACK]; VIACS = cs[VIA]; IWMCS = cs[IWM];
    SCCCS = cs[SCC]; SCSICS = cs[SCSI]; SndCS = cs[SND];
  endtask

  task automatic setEn(input logic [5:0] en);
    SlowIACK = en[IACK]; SlowVIA = en[VIA]; SlowIWM = en[IWM];
    SlowSCC = en[SCC]; SlowSCSI = en[SCSI]; SlowSnd = en[SND];
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, compare at negedge.
  task automatic step(input string tag, input logic bact, input int dev,
                      input logic tick, input logic ack, input logic [3:0] exp);
    logic [3:0] obs;
    logic [3:0] e;
    string      t;
    BACT = bact; setCs(dev); Tick = tick; SlowAck = ack;
    sbQ.push_back(exp);
    tagQ.push_back(tag);
    @(negedge CLK);
    obs = {SlowReq, BusHold, ClockGate, SlowActive};
    e = sbQ.pop_front();
    t = tagQ.pop_front();
    chkEq(t, obs, e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nPOR = 1'b0; BACT = 1'b0; Tick = 1'b0; SlowAck = 1'b0;
    setCs(NONE); setEn(6'b000110);
    SlowClockGate = 1'b0; SlowTimeout = 4'd2;
    @(posedge CLK); #1;

    // Reset state; BusHold still follows Hit under reset.
    step("rst_idle", 0, NONE, 0, 0, 4'b0000);
    step("rst_hit",  1, VIA,  0, 0, 4'b0100);
    nPOR = 1'b1;
    step("rst_rel",  0, NONE, 0, 0, 4'b0000);

    // 1: VIA slow access, ack two cycles after request, 32-tick hold.
    step("s1_hit",  1, VIA, 0, 0, 4'b0100);
    step("s1_req",  1, VIA, 0, 0, 4'b1100);
    step("s1_req",  1, VIA, 0, 0, 4'b1100);
    step("s1_ack",  1, VIA, 0, 1, 4'b1100);
    step("s1_slow", 1, VIA, 0, 1, 4'b1001);
    for (int i = 0; i < 32; i++) step("s1_hold", 0, NONE, 1, 1, 4'b1001);
    step("s1_exit",   0, NONE, 0, 1, 4'b1001);
    step("s1_tofast", 0, NONE, 0, 1, 4'b0000);
    step("s1_ackdn",  0, NONE, 0, 0, 4'b0000);
    step("s1_fast",   0, NONE, 0, 0, 4'b0000);

    // 2: SCC not enabled for slow -> nothing happens.
    for (int i = 0; i < 3; i++) step("s2_scc", 1, SCC, 1, 0, 4'b0000);
    step("s2_idle", 0, NONE, 0, 0, 4'b0000);

    // 3: IWM rehit at count 5 with Tick -> reload to 0x20 wins.
    step("s3_hit",  1, IWM, 0, 0, 4'b0100);
    step("s3_ack",  1, IWM, 0, 1, 4'b1100);
    step("s3_slow", 1, IWM, 0, 1, 4'b1001);
    for (int i = 0; i < 27; i++) step("s3_dec", 0, NONE, 1, 1, 4'b1001);
    step("s3_rehit", 1, IWM, 1, 1, 4'b1001);
    for (int i = 0; i < 32; i++) step("s3_hold", 0, NONE, 1, 1, 4'b1001);
    step("s3_exit",  0, NONE, 0, 1, 4'b1001);
    step("s3_ackdn", 0, NONE, 0, 0, 4'b0000);
    step("s3_fast",  0, NONE, 0, 0, 4'b0000);

    // 4: zero hold; non-slow BACT blocks exit; hit during TOFAST.
    SlowTimeout = 4'd0;
    step("s4_hit",   1, VIA,  0, 0, 4'b0100);
    step("s4_ack",   1, VIA,  0, 1, 4'b1100);
    step("s4_slow",  1, VIA,  0, 1, 4'b1001);
    step("s4_block", 1, SCC,  0, 1, 4'b1001);
    step("s4_exit",  0, NONE, 0, 1, 4'b1001);
    step("s4_tfhit", 1, VIA,  0, 1, 4'b0100);
    step("s4_tfhit", 1, VIA,  0, 1, 4'b0100);
    step("s4_ackdn", 1, VIA,  0, 0, 4'b0100);
    step("s4_rereq", 1, VIA,  0, 0, 4'b1100);
    step("s4_ack",   1, VIA,  0, 1, 4'b1100);
    step("s4_slow",  1, VIA,  0, 1, 4'b1001);
    step("s4_exit",  0, NONE, 0, 1, 4'b1001);
    step("s4_ackdn", 0, NONE, 0, 0, 4'b0000);
    step("s4_fast",  0, NONE, 0, 0, 4'b0000);

    // 5: ClockGate only in SLOW; then SlowAck lost while SLOW.
    SlowClockGate = 1'b1;
    step("s5_hit",   1, VIA,  0, 0, 4'b0100);
    step("s5_ack",   1, VIA,  0, 1, 4'b1100);
    step("s5_slow",  1, VIA,  0, 1, 4'b1011);
    step("s5_exit",  0, NONE, 0, 1, 4'b1011);
    step("s5_tofast",0, NONE, 0, 1, 4'b0000);
    step("s5_ackdn", 0, NONE, 0, 0, 4'b0000);
    step("s5e_hit",  1, VIA,  0, 0, 4'b0100);
    step("s5e_ack",  1, VIA,  0, 1, 4'b1100);
    step("s5e_slow", 1, VIA,  0, 1, 4'b1011);
    step("s5e_lost", 1, SCC,  0, 0, 4'b1011);
    step("s5e_rereq",1, VIA,  0, 0, 4'b1100);
    step("s5e_ack",  1, VIA,  0, 1, 4'b1100);
    step("s5e_slow", 0, NONE, 0, 1, 4'b1011);
    step("s5e_ackdn",0, NONE, 0, 0, 4'b0000);
    step("s5e_fast", 0, NONE, 0, 0, 4'b0000);

    // 6: asynchronous reset mid-SLOW, then normal operation resumes.
    SlowTimeout = 4'd2;
    step("s6_hit",  1, VIA,  0, 0, 4'b0100);
    step("s6_ack",  1, VIA,  0, 1, 4'b1100);
    step("s6_slow", 0, NONE, 0, 1, 4'b1011);
    #2 nPOR = 1'b0;
    #1 chkEq("s6_por", {SlowReq, 1'b0, ClockGate, SlowActive}, 4'b0000);
    #1 nPOR = 1'b1;
    @(posedge CLK); #1;
    SlowTimeout = 4'd0;
    step("s6_idle",  0, NONE, 0, 0, 4'b0000);
    step("s6_hit",   1, VIA,  0, 0, 4'b0100);
    step("s6_req",   1, VIA,  0, 0, 4'b1100);
    step("s6_ack",   1, VIA,  0, 1, 4'b1100);
    step("s6_slow",  1, VIA,  0, 1, 4'b1011);
    step("s6_exit",  0, NONE, 0, 1, 4'b1011);
    step("s6_ackdn", 0, NONE, 0, 0, 4'b0000);
    step("s6_fast",  0, NONE, 0, 0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
